// File: rtl/if_prefetch_queue.sv
// ============================================================================
// if_prefetch_queue
// ----------------------------------------------------------------------------
// Instruction-fetch front end that sits directly upstream of the IF/ID
// pipeline register. It issues in-order word fetches to instruction memory,
// buffers the returned instructions in a DEPTH-entry FIFO, and presents
// {instruction, PC+4} to IF/ID with a valid/ready handshake. Decode stalls
// therefore never lose fetches. A taken branch from MEM (redirect_valid)
// flushes the queue, discards every fetch still in flight, and restarts
// fetching at the branch target.
//
// Optional build macro:
//   IFQ_BYPASS_EN - when defined, a response that arrives while the queue is
//                   empty and IF/ID is ready is forwarded combinationally to
//                   the id_* outputs instead of being written to storage.
//                   This removes one cycle of empty-queue latency.
//
// Parameters:
//   DEPTH     FIFO entries, and the cap on queued plus in-flight fetches
//             (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   redirect_valid   in   taken branch from MEM, single-cycle pulse
//   redirect_pc      in   branch target (low two bits ignored)
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts the request
//   imem_req_addr    out  word address of the fetch
//   imem_resp_valid  in   returned instruction valid (in request order)
//   imem_resp_data   in   returned instruction
//   id_valid         out  head entry valid toward IF/ID
//   id_ready         in   IF/ID can accept (not stalled)
//   id_instr         out  instruction to IF/ID
//   id_pc_plus4      out  fetch address + 4
// ============================================================================
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters must hold the value DEPTH itself.
    localparam int CW = $clog2(DEPTH + 1);
    // Drop counter accumulates across back-to-back redirects, so it is
    // wider than the in-flight cap.
    localparam int DW = CW + 4;

    localparam logic [CW:0]  DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          active_q;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [DW-1:0] drop;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc_n;
    logic [31:0]   resp_pc_n;
    logic [AW-1:0] head_ptr_n;
    logic [AW-1:0] tail_ptr_n;
    logic [CW-1:0] count_n;
    logic [CW-1:0] outstanding_n;
    logic [DW-1:0] drop_n;

    logic [CW:0]   credit_sum;
    logic [31:0]   redirect_target;
    logic [31:0]   resp_pc_plus4;
    logic          req_fire;
    logic          resp_take;
    logic          resp_drop;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          queue_nonempty;

    assign credit_sum      = {1'b0, count} + {1'b0, outstanding};
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign resp_pc_plus4   = resp_pc + 32'd4;
    assign queue_nonempty  = (count != '0);

    // active_q holds off the very first request until one edge after reset
    // release, so the request channel is quiet while rst_n is low.
    assign imem_req_valid = active_q && !redirect_valid && (credit_sum < DEPTH_SUM);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when no stale fetches remain to be discarded
    // and no redirect is flushing the stream this same cycle.
    assign resp_take = imem_resp_valid && !redirect_valid && (drop == '0);
    assign resp_drop = imem_resp_valid && !resp_take;

`ifdef IFQ_BYPASS_EN
    // Forward only into an empty queue. If the last entry is being popped
    // this cycle it already occupies the id_* outputs, so the arriving
    // response is written to storage as usual.
    assign bypass = resp_take && !queue_nonempty && id_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_take && !bypass;
    assign pop  = queue_nonempty && id_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // Output presentation
    // ------------------------------------------------------------------
    // Data outputs read zero whenever nothing is valid, which also gives
    // the required reset values without resetting the storage array.
    always_comb begin
        id_valid    = queue_nonempty || bypass;
        id_instr    = '0;
        id_pc_plus4 = '0;
        if (bypass) begin
            id_instr    = imem_resp_data;
            id_pc_plus4 = resp_pc_plus4;
        end else if (queue_nonempty) begin
            id_instr    = instr_mem[head_ptr];
            id_pc_plus4 = pc4_mem[head_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        head_ptr_n    = head_ptr;
        tail_ptr_n    = tail_ptr;
        count_n       = count;
        outstanding_n = outstanding;
        drop_n        = drop;

        if (redirect_valid) begin
            // Everything in flight becomes stale; a response arriving right
            // now is one of those stale fetches and is consumed here.
            fetch_pc_n    = redirect_target;
            resp_pc_n     = redirect_target;
            head_ptr_n    = '0;
            tail_ptr_n    = '0;
            count_n       = '0;
            outstanding_n = '0;
            drop_n        = drop + DW'(outstanding) - DW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
            if (resp_take) begin
                resp_pc_n = resp_pc_plus4;
            end
            if (resp_drop) begin
                drop_n = drop - DW'(1);
            end

            case ({req_fire, resp_take})
                2'b10:   outstanding_n = outstanding + CW'(1);
                2'b01:   outstanding_n = outstanding - CW'(1);
                default: outstanding_n = outstanding;
            endcase

            if (push) begin
                tail_ptr_n = tail_ptr + AW'(1);
            end
            if (pop) begin
                head_ptr_n = head_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count_n = count + CW'(1);
                2'b01:   count_n = count - CW'(1);
                default: count_n = count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            active_q    <= 1'b1;
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            head_ptr    <= head_ptr_n;
            tail_ptr    <= tail_ptr_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            drop        <= drop_n;
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (data only, not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_ptr] <= imem_resp_data;
            pc4_mem[tail_ptr]   <= resp_pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    // The credit rule makes a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == DEPTH_CNT)));

    // Every response must match a fetch that is either still owed to the
    // queue or marked for discard.
    a_resp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> ((drop != '0) || (outstanding != '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ============================================================================
// tb_if_prefetch_queue
// ----------------------------------------------------------------------------
// Directed bench for if_prefetch_queue (DEPTH=4, RESET_PC=0). A small
// instruction memory with one cycle of latency answers every accepted fetch
// with 32'hC0DE_0000 | addr[15:0]; it can be held off with mem_stall.
// Inputs are driven on the falling edge and outputs are sampled there too.
// ============================================================================
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;

    logic        mem_stall = 1'b0;
    logic [31:0] pend [$];
    logic [31:0] pend_addr;

    int checks = 0;
    int errors = 0;

    if_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc_plus4     (id_pc_plus4)
    );

    always #5 clk = ~clk;

    // Instruction memory: capture accepted requests on the edge, answer the
    // oldest one just after it, so a fetch accepted on edge k returns on k+1.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
            end
            #1;
            if (pend.size() != 0 && !mem_stall) begin
                pend_addr       = pend.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = 32'hC0DE_0000 | {16'h0000, pend_addr[15:0]};
            end else begin
                imem_resp_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk ({tag, "_req_addr"},  imem_req_addr,  32'h0000_0000);
        chk1({tag, "_id_valid"},  id_valid,       1'b0);
        chk ({tag, "_id_instr"},  id_instr,       32'h0000_0000);
        chk ({tag, "_id_pc4"},    id_pc_plus4,    32'h0000_0000);
    endtask

    initial begin
        // ---------------- reset state ----------------
        cyc(1);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // ---------------- streaming, latency 1 ----------------
        cyc(1);
        chk1("s_req_valid0", imem_req_valid, 1'b1);
        chk ("s_req_addr0",  imem_req_addr,  32'h0000_0000);
        cyc(1);
        chk ("s_req_addr1",  imem_req_addr,  32'h0000_0004);
        chk1("s_id_valid_lat", id_valid,     1'b0);
        cyc(1);
        chk1("s_id_valid0",  id_valid,       1'b1);
        chk ("s_instr0",     id_instr,       32'hC0DE_0000);
        chk ("s_pc4_0",      id_pc_plus4,    32'h0000_0004);
        chk ("s_req_addr2",  imem_req_addr,  32'h0000_0008);
        cyc(1);
        chk ("s_instr1",     id_instr,       32'hC0DE_0004);
        chk ("s_pc4_1",      id_pc_plus4,    32'h0000_0008);
        cyc(1);
        chk ("s_instr2",     id_instr,       32'hC0DE_0008);
        chk ("s_pc4_2",      id_pc_plus4,    32'h0000_000C);

        // ---------------- decode stall: credit cap ----------------
        id_ready = 1'b0;
        cyc(3);
        chk1("st_req_blocked", imem_req_valid, 1'b0);
        chk1("st_id_valid",    id_valid,       1'b1);
        chk ("st_head_a",      id_instr,       32'hC0DE_0008);
        cyc(6);
        chk1("st_req_blocked2", imem_req_valid, 1'b0);
        chk ("st_head_b",      id_instr,       32'hC0DE_0008);
        chk ("st_head_pc4",    id_pc_plus4,    32'h0000_000C);
        cyc(1);
        id_ready = 1'b1;
        cyc(1);
        chk ("st_pop0",        id_instr,       32'hC0DE_000C);
        chk ("st_pop0_pc4",    id_pc_plus4,    32'h0000_0010);
        chk1("st_resume_valid", imem_req_valid, 1'b1);
        chk ("st_resume_addr", imem_req_addr,  32'h0000_0018);
        cyc(1);
        chk ("st_pop1",        id_instr,       32'hC0DE_0010);
        cyc(1);
        chk ("st_pop2",        id_instr,       32'hC0DE_0014);
        cyc(1);
        chk ("st_pop3",        id_instr,       32'hC0DE_0018);
        chk ("st_pop3_pc4",    id_pc_plus4,    32'h0000_001C);

        // ---------------- redirect with two fetches in flight ----------------
        mem_stall = 1'b1;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk ("r1_req_addr0", imem_req_addr, 32'h0000_0000);
        cyc(2);
        chk ("r1_req_addr2", imem_req_addr, 32'h0000_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk1("r1_no_req_on_redirect", imem_req_valid, 1'b0);
        cyc(1);
        redirect_valid = 1'b0;
        mem_stall      = 1'b0;
        #1;
        chk1("r1_req_valid", imem_req_valid, 1'b1);
        chk ("r1_req_addr",  imem_req_addr,  32'h0000_0100);
        chk1("r1_id_valid_flushed", id_valid, 1'b0);
        cyc(1);
        chk1("r1_drop_a", id_valid, 1'b0);
        cyc(1);
        chk1("r1_drop_b", id_valid, 1'b0);
        cyc(1);
        chk1("r1_wait",   id_valid, 1'b0);
        cyc(1);
        chk1("r1_id_valid", id_valid,    1'b1);
        chk ("r1_instr",    id_instr,    32'hC0DE_0100);
        chk ("r1_pc4",      id_pc_plus4, 32'h0000_0104);

        // ---------------- misaligned target, redirect + response + pop ----------------
        // A response (0x104) is on the bus and the head (0x100) is popping.
        chk1("r2_resp_present", imem_resp_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        chk1("r2_no_req_on_redirect", imem_req_valid, 1'b0);
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        chk1("r2_id_valid_flushed", id_valid,      1'b0);
        chk1("r2_req_valid",        imem_req_valid, 1'b1);
        chk ("r2_req_addr_aligned", imem_req_addr,  32'h0000_0200);
        cyc(1);
        chk1("r2_drop_a", id_valid, 1'b0);
        cyc(1);
        chk1("r2_drop_b", id_valid, 1'b0);
        cyc(1);
        chk1("r2_id_valid", id_valid,    1'b1);
        chk ("r2_instr",    id_instr,    32'hC0DE_0200);
        chk ("r2_pc4",      id_pc_plus4, 32'h0000_0204);

        // ---------------- asynchronous reset mid-stream ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("ar");
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk1("ar_req_valid", imem_req_valid, 1'b1);
        chk ("ar_req_addr",  imem_req_addr,  32'h0000_0000);
        chk1("ar_id_empty",  id_valid,       1'b0);
        cyc(2);
        chk1("ar_id_valid",  id_valid,       1'b1);
        chk ("ar_instr",     id_instr,       32'hC0DE_0000);
        chk ("ar_pc4",       id_pc_plus4,    32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
